// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the MAC sequencer.
package mac_seq_pkg;

  localparam int MAC_DATA_W = 8;
  localparam int MAC_ACC_W  = 32;
  localparam int MAC_LEN_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    DONE
  } mac_seq_state_e;

endpackage

// File: rtl/mac_seq_ctrl.sv
// Sequencer for a sibling signed MAC: clears it, streams a job's operand
// pairs into it and returns the final accumulator as the dot-product.
// Optional build macro MAC_SEQ_CTRL_PERF_EN adds stall_cnt and job_done.
//
// state | meaning
// IDLE  | waiting for start; all outputs quiet
// CLEAR | one cycle of mac_clear before any accumulation
// ACCUM | accepting operand pairs until the job count is exhausted
// DRAIN | last product lands in the MAC; result captured at the edge
// DONE  | result presented until the consumer takes it
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W,
  parameter int ACC_W  = MAC_ACC_W,
  parameter int LEN_W  = MAC_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              mac_en,
  output logic              mac_clear,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data
`ifdef MAC_SEQ_CTRL_PERF_EN
  ,
  output logic [LEN_W-1:0]  stall_cnt,
  output logic              job_done
`endif
);

  mac_seq_state_e state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;

  // Next-state, job counter, result capture and combinational outputs.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy        = 1'b1;
    in_ready    = 1'b0;
    mac_en      = 1'b0;
    mac_clear   = 1'b0;
    mac_a       = '0;
    mac_b       = '0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          remaining_d = len;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        mac_clear = 1'b1;
        state_d   = (remaining_q != '0) ? ACCUM : DRAIN;
      end
      ACCUM: begin
        in_ready = 1'b1;
        mac_en   = in_valid;
        mac_a    = in_a;
        mac_b    = in_b;
        if (in_valid) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_data_d  = mac_acc;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef MAC_SEQ_CTRL_PERF_EN
  logic [LEN_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             job_done_q, job_done_d;

  // Stall counter restarts with each job and saturates; done pulse marks the result hand-off.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE && start) begin
      stall_cnt_d = '0;
    end else if (state_q == ACCUM && !in_valid && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + LEN_W'(1);
    end
    job_done_d = (state_q == DONE) && out_ready;
  end

  // Performance registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      job_done_q  <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      job_done_q  <= job_done_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign job_done  = job_done_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl with a behavioural MAC sibling.
module tb_mac_seq_ctrl;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a, in_b;
  logic              mac_en, mac_clear;
  logic [DATA_W-1:0] mac_a, mac_b;
  logic [ACC_W-1:0]  mac_acc;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
`ifdef MAC_SEQ_CTRL_PERF_EN
  logic [LEN_W-1:0]  stall_cnt;
  logic              job_done;
`endif

  always #5 clk = ~clk;

  mac_seq_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_en(mac_en), .mac_clear(mac_clear), .mac_a(mac_a), .mac_b(mac_b),
    .mac_acc(mac_acc), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
`ifdef MAC_SEQ_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .job_done(job_done)
`endif
  );

  // Sibling MAC: not reset, so only the sequencer's CLEAR removes residue.
  logic signed [ACC_W-1:0] acc = '0;
  always @(posedge clk) begin
    if (mac_clear) acc <= '0;
    else if (mac_en) acc <= acc + $signed(mac_a) * $signed(mac_b);
  end
  assign mac_acc = acc;

  int n_tests = 0;
  int n_fail  = 0;
  int q_a[$];
  int q_b[$];
  int q_gap[$];

  task automatic add_pair(input int a, input int b, input int gap);
    q_a.push_back(a);
    q_b.push_back(b);
    q_gap.push_back(gap);
  endtask

  task automatic clear_job();
    q_a.delete();
    q_b.delete();
    q_gap.delete();
  endtask

  // Runs the queued job; q_gap[i] idle cycles precede pair i (i>0).
  task automatic run_job(input string nm, input int hold, input bit poke_start);
    int n;
    logic signed [31:0] exp_sum;
    int idx, gap_left, edges, hs_edge, ov_edge, clears, stalls_exp, budget;
    bit saw_ready, saw_en, hs, stable;
    n = q_a.size();
    exp_sum = 0;
    stalls_exp = 0;
    for (int i = 0; i < n; i++) begin
      exp_sum += q_a[i] * q_b[i];
      if (i > 0) stalls_exp += q_gap[i];
    end
    idx = 0; gap_left = 0; hs_edge = -1; ov_edge = -1; clears = 0;
    saw_ready = 1'b0; saw_en = 1'b0;
    budget = 40 + n * 10;

    @(negedge clk);
    start = 1'b1; len = LEN_W'(n); in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    edges = 1;
    #1 start = 1'b0; len = LEN_W'($urandom);

    while (ov_edge < 0 && edges < budget) begin
      @(negedge clk);
      if (idx < n && gap_left == 0) begin
        in_valid = 1'b1; in_a = 8'(q_a[idx]); in_b = 8'(q_b[idx]);
      end else begin
        in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
      end
      #1;
      if (out_valid) begin
        ov_edge = edges;
      end else begin
        if (mac_clear) clears++;
        if (in_ready) saw_ready = 1'b1;
        if (mac_en) saw_en = 1'b1;
        hs = in_valid && in_ready;
        @(posedge clk);
        edges++;
        if (hs) begin
          hs_edge = edges;
          idx++;
          if (idx < n) gap_left = q_gap[idx];
        end else if (!in_valid && gap_left > 0) begin
          gap_left--;
        end
      end
    end
    in_valid = 1'b0;

    n_tests++;
    if (ov_edge < 0) begin
      n_fail++;
      $display("FAIL %s timeout: out_valid not seen within %0d edges", nm, budget);
      return;
    end
    n_tests++;
    if (clears !== 1) begin
      n_fail++;
      $display("FAIL %s mac_clear pulses got %0d exp 1", nm, clears);
    end
    if (n == 0) begin
      n_tests++;
      if (saw_ready || saw_en) begin
        n_fail++;
        $display("FAIL %s zero-len activity in_ready=%0b mac_en=%0b exp 0", nm, saw_ready, saw_en);
      end
      n_tests++;
      if (ov_edge !== 3) begin
        n_fail++;
        $display("FAIL %s len0 latency got %0d edges exp 3", nm, ov_edge);
      end
    end else begin
      n_tests++;
      if (ov_edge - hs_edge + 1 !== 2) begin
        n_fail++;
        $display("FAIL %s latency after last handshake got %0d edges exp 2", nm, ov_edge - hs_edge + 1);
      end
    end
    n_tests++;
    if (out_data !== exp_sum || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s result got %0d busy=%0b exp %0d busy=1", nm, $signed(out_data), busy, exp_sum);
    end
`ifdef MAC_SEQ_CTRL_PERF_EN
    n_tests++;
    if (stall_cnt !== LEN_W'(stalls_exp)) begin
      n_fail++;
      $display("FAIL %s stall_cnt got %0d exp %0d", nm, stall_cnt, stalls_exp);
    end
`endif

    stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      start = poke_start ? 1'($urandom) : 1'b0;
      len = LEN_W'($urandom);
      @(posedge clk);
      @(negedge clk);
      #1;
      if (!(out_valid === 1'b1 && out_data === exp_sum && busy === 1'b1)) stable = 1'b0;
    end
    if (hold > 0) begin
      n_tests++;
      if (!stable) begin
        n_fail++;
        $display("FAIL %s DONE hold not stable: out_valid=%0b out_data=%0d exp 1/%0d", nm, out_valid, $signed(out_data), exp_sum);
      end
    end

    out_ready = 1'b1;
    start = poke_start;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    start = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== exp_sum) begin
      n_fail++;
      $display("FAIL %s after accept out_valid=%0b busy=%0b out_data=%0d exp 0/0/%0d", nm, out_valid, busy, $signed(out_data), exp_sum);
    end
`ifdef MAC_SEQ_CTRL_PERF_EN
    n_tests++;
    if (job_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s job_done got %0b exp 1", nm, job_done);
    end
`endif
    @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start in DONE not ignored busy=%0b out_valid=%0b exp 0/0", nm, busy, out_valid);
    end
`ifdef MAC_SEQ_CTRL_PERF_EN
    n_tests++;
    if (job_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s job_done not a pulse got %0b exp 0", nm, job_done);
    end
`endif
  endtask

  task automatic check_quiet(input string nm);
    n_tests++;
    if ({busy, in_ready, mac_en, mac_clear, out_valid} !== 5'b0 ||
        mac_a !== 8'h0 || mac_b !== 8'h0 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL %s outputs not zero busy=%0b in_ready=%0b mac_en=%0b mac_clear=%0b out_valid=%0b mac_a=%0h mac_b=%0h out_data=%0h exp all 0",
               nm, busy, in_ready, mac_en, mac_clear, out_valid, mac_a, mac_b, out_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    clear_job();
    add_pair(3, 4, 0);
    add_pair(5, -2, 0);
    run_job("basic_len2", 0, 1'b0);
  endtask

  task automatic test_zero_len();
    clear_job();
    run_job("zero_len", 0, 1'b0);
  endtask

  task automatic test_gaps();
    clear_job();
    add_pair(-128, -128, 0);
    add_pair(127, 1, 2);
    add_pair(-1, 1, 2);
    run_job("gaps_len3", 0, 1'b0);
  endtask

  task automatic test_done_hold();
    clear_job();
    add_pair(-7, 9, 0);
    add_pair(100, 100, 1);
    run_job("done_hold", 5, 1'b1);
    clear_job();
    add_pair(11, -11, 0);
    run_job("after_hold", 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; len = 16'd4;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'd5; in_b = 8'd9;
    @(posedge clk);
    @(posedge clk);
    #3;
    in_a = 8'd2; in_b = 8'd3;
    rst = 1'b1;
    #1;
    check_quiet("reset_mid_accum");
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    clear_job();
    add_pair(7, 6, 0);
    run_job("after_reset", 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    clear_job();
    add_pair(2, 2, 0);
    run_job("b2b_job1", 0, 1'b0);
    clear_job();
    add_pair(-3, 3, 0);
    run_job("b2b_job2", 0, 1'b0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      int n;
      clear_job();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        add_pair(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 3)));
      run_job($sformatf("random_%0d", j), int'($urandom_range(0, 3)), 1'($urandom));
    end
  endtask

  initial begin
    start = 1'b0; len = '0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_zero_len();
    test_gaps();
    test_done_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer for the signed MAC datapath (8-bit operands, 32-bit accumulator, en/clear controls).
- Accepts a job (vector length), clears the MAC, streams operand pairs from a valid/ready source into the MAC, and returns the dot-product via valid/ready.
- Sits between the matrix accelerator's operand fetch logic and one mac instance; the parent wrapper instantiates both side by side.

Parameters:
- DATA_W, 8, operand width (signed); must match the MAC.
- ACC_W, 32, accumulator/result width (signed); must match the MAC.
- LEN_W, 16, job length width; max job = 2^LEN_W-1 elements.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  element count, captured with start; 0 is legal.
- busy  out  1  high whenever state != IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller accepts a pair.
- in_a, in_b  in  DATA_W  signed operands.
- mac_en  out  1  MAC enable.
- mac_clear  out  1  MAC synchronous clear.
- mac_a, mac_b  out  DATA_W  MAC operands.
- mac_acc  in  ACC_W  MAC accumulator value.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_data  out  ACC_W  signed dot-product result.

Behaviour:
- MAC contract: at each clock edge, clear=1 sets acc=0 (clear has priority); otherwise en=1 sets acc=acc+a*b. acc is a register.
- States: IDLE, CLEAR, ACCUM, DRAIN, DONE. Reset (async): IDLE, remaining=0, out_valid=0, out_data=0.
- All mac_* outputs, in_ready and busy decode combinationally from the registered state plus in_valid/in_a/in_b. In IDLE they are all 0, so every output is 0 in reset.
- IDLE: start=1 captures len into remaining, then goes to CLEAR. start outside IDLE is ignored.
- CLEAR (1 cycle): mac_clear=1. Next state is ACCUM if remaining != 0, else DRAIN.
- ACCUM: in_ready=1, mac_en=in_valid, mac_a=in_a, mac_b=in_b. On a handshake, remaining decrements; if remaining==1, go to DRAIN. in_valid gaps stall with no MAC activity.
- DRAIN (1 cycle): mac_acc now holds the final sum. At the edge, out_data<=mac_acc, out_valid<=1, go to DONE.
- DONE: out_valid=1 and out_data held stable until out_ready=1. At that edge out_valid<=0 and state goes to IDLE. A start in that same cycle is ignored; the next job starts from IDLE.
- Latency: out_valid rises 2 edges after the last operand handshake. For len=0, out_valid rises 3 edges after start.
- No arithmetic in the controller. Overflow wraps in the MAC; out_data is passed through unmodified.
- rst mid-job: immediate IDLE. MAC contents are irrelevant because every job begins with CLEAR.

Optional Feature:
- MAC_SEQ_CTRL_PERF_EN defined: adds two outputs.
  - stall_cnt [LEN_W-1:0]: counts ACCUM cycles with in_valid=0. Zeroed on entry to CLEAR; saturates at all-ones; held through DONE/IDLE.
  - job_done: 1-cycle pulse on the out_valid&&out_ready edge.
- Undefined: neither port exists; no logic is added.

Decomposition:
- Package mac_seq_pkg holds:
  - state enum mac_seq_state_e (IDLE, CLEAR, ACCUM, DRAIN, DONE);
  - default width constants MAC_DATA_W=8, MAC_ACC_W=32, MAC_LEN_W=16.
- Single module; no sub-module. The MAC is a sibling in the parent, not instantiated here.

Test Plan:
- start, len=2; pairs (3,4),(5,-2) back-to-back; out_ready=1 -> mac_clear pulses once; out_data=2; out_valid high 1 cycle; busy back to 0.
- start, len=0 -> no in_ready, no mac_en; out_data=0; out_valid 3 edges after start.
- len=3, pairs (-128,-128),(127,1),(-1,1), with in_valid low for 2 cycles between pairs -> out_data=16510; stall_cnt=4 when PERF_EN is defined.
- Job done with out_ready held low 5 cycles -> out_valid/out_data stable for all 5; start pulses during DONE are ignored; a new start after return to IDLE runs correctly.
- rst asserted mid-ACCUM after 1 of 4 pairs -> all outputs 0 immediately. Then start, len=1, pair (7,6) -> out_data=42, with no residue from the aborted job.
- Back-to-back jobs: job1 len=1 (2,2) -> 4; job2 len=1 (-3,3) -> -9 (confirms CLEAR between jobs).
